ramw_sched: RTL and testbench

Round-robin scheduler that shares one 96-bit frame writer (12-byte serialiser feeding the egress FIFO over an `fs`/`fd` handshake) between four requesters. It arbitrates among pending requests and latches the winner's 96-bit word onto the writer's data input. It then runs the start/done handshake, acknowledges the requester, and aborts with a sticky error if the writer never completes. The block sits between the channel sample collectors and the frame writer in the MAC transmit path.

---
 rtl/ramw_sched_if.sv | 24 ++
 rtl/ramw_sched.sv | 96 +++++++++
 tb/tb_ramw_sched.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ramw_sched_if.sv
// Signal bundle between the sample collectors, the round-robin scheduler and the frame writer.
// req/ack: req[i] is a level held until the one-cycle ack[i]; wr_fs/wr_fd: wr_fs stays high until wr_fd is seen.
interface ramw_sched_if;
   logic [3:0]   req;
   logic [383:0] req_data;
   logic [3:0]   ack;
   logic [95:0]  wr_data;
   logic         wr_fs;
   logic         wr_fd;
   logic [1:0]   grant_id;
   logic         busy;
   logic         err;
   logic [7:0]   so;

   modport master (
      input  req, req_data, wr_fd,
      output ack, wr_data, wr_fs, grant_id, busy, err, so
   );

   modport slave (
      output req, req_data, wr_fd,
      input  ack, wr_data, wr_fs, grant_id, busy, err, so
   );
endinterface

// File: rtl/ramw_sched.sv
// Round-robin scheduler sharing one 96-bit frame writer between four requesters,
// with a frame-done timeout that raises a sticky error and drains before re-arbitrating.
module ramw_sched #(
   parameter int TIMEOUT = 64,
   parameter int DRAIN   = 16
) (
   input  logic           clk,
   input  logic           rst,
   ramw_sched_if.master   bus
);

   typedef enum logic [7:0] {
      IDLE = 8'h00,
      ARB  = 8'h01,
      LOAD = 8'h02,
      SEND = 8'h03,
      HOLD = 8'h04,
      DONE = 8'h05,
      ERR  = 8'h0F
   } state_t;

   localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
   localparam logic [15:0] DRAIN_LAST = 16'(DRAIN - 1);

   state_t      state, state_nxt;
   logic [15:0] cnt;
   logic [1:0]  arb_idx;
   logic [1:0]  win;
   logic        win_vld;
   logic [95:0] sel_word;

   // First pending requester after the last grant, wrapping around.
   always_comb begin
      win     = 2'd0;
      win_vld = 1'b0;
      arb_idx = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         arb_idx = bus.grant_id + 2'(k);
         if (!win_vld && bus.req[arb_idx]) begin
            win     = arb_idx;
            win_vld = 1'b1;
         end
      end
   end

   always_comb sel_word = bus.req_data[9'(bus.grant_id) * 9'd96 +: 96];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (|bus.req) state_nxt = ARB;
         ARB:  state_nxt = win_vld ? LOAD : IDLE;
         LOAD: state_nxt = SEND;
         SEND: begin
            if (bus.wr_fd)           state_nxt = HOLD;
            else if (cnt == TO_LAST) state_nxt = ERR;
         end
         HOLD: if (!bus.wr_fd) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         ERR:  if (cnt == DRAIN_LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         bus.grant_id <= 2'd3;
         bus.wr_data  <= 96'h0;
         bus.err      <= 1'b0;
         cnt          <= 16'd0;
      end else begin
         state <= state_nxt;
         case (state)
            ARB: if (win_vld) bus.grant_id <= win;
            LOAD: begin
               bus.wr_data <= sel_word;
               cnt         <= 16'd0;
            end
            // The same counter times the drain, so it restarts on the way into ERR.
            SEND: cnt <= (state_nxt == ERR) ? 16'd0 : cnt + 16'd1;
            ERR: begin
               bus.err <= 1'b1;
               cnt     <= cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.wr_fs = (state == SEND);
   assign bus.ack   = (state == DONE) ? 4'(4'b0001 << bus.grant_id) : 4'b0000;
   assign bus.busy  = (state != IDLE);
   assign bus.so    = state;

endmodule

// File: tb/tb_ramw_sched.sv
// Bench for ramw_sched: frame writer model, stimulus table, hand-written corner cases,
// and randomized request sets checked against a round-robin service-order model.
module tb_ramw_sched;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ramw_sched_if bus();

   ramw_sched #(.TIMEOUT(64), .DRAIN(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vec = 0;
   int miscmp = 0;

   // Writer model: PREP, BEGN, 12 data bytes, then frame done after wr_lat cycles of wr_fs.
   int   wr_lat = 15;
   bit   wr_on = 1'b1;
   int   wcnt = 0;
   logic [7:0] byte_q[$];

   logic [95:0] fs_word = '0;
   bit   fs_d = 1'b0;
   int   ack_cnt = 0;

   logic [95:0] exp_q[$];
   int          exp_id_q[$];
   logic [95:0] rq[4][$];
   int          model_last;

   typedef struct {
      logic [3:0] pat;
      logic [3:0] ack;
      logic [1:0] gid;
   } vec_t;
   vec_t tbl[15];

   always @(negedge clk) begin
      if (rst) begin
         wcnt = 0;
         bus.wr_fd = 1'b0;
      end else if (bus.wr_fs) begin
         wcnt++;
         if (wcnt >= 3 && wcnt <= 14) byte_q.push_back(bus.wr_data[(95 - 8 * (wcnt - 3)) -: 8]);
         if (wr_on && wcnt == wr_lat) bus.wr_fd = 1'b1;
      end else begin
         wcnt = 0;
         bus.wr_fd = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (bus.wr_fs && !fs_d) fs_word = bus.wr_data;
      fs_d = bus.wr_fs;
      if (bus.ack != 4'b0) ack_cnt++;
   end

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      vec++;
      if (act !== exp) begin
         miscmp++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [95:0] word_of(input int i);
      return {8'(i), 88'h12_3456_789A_BCDE_F012_3456};
   endfunction

   task automatic wait_ack(output logic [3:0] a, input int budget);
      int n = 0;
      while (bus.ack == 4'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      a = bus.ack;
      chk("ack_wait", 96'(bus.ack != 4'b0), 96'd1);
   endtask

   // Returns on the first negedge with wr_fs low after a high run.
   task automatic fs_len(output int len);
      int n = 0;
      while (!bus.wr_fs && n < 300) begin
         @(negedge clk);
         n++;
      end
      len = 0;
      while (bus.wr_fs && len < 300) begin
         @(negedge clk);
         len++;
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      bus.req = 4'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_frame(input logic [3:0] pat, input logic [3:0] exp_ack,
                            input logic [1:0] exp_gid, input string tag);
      logic [3:0] a;
      @(negedge clk);
      bus.req = pat;
      wait_ack(a, 300);
      chk({tag, "_ack"}, a, exp_ack);
      chk({tag, "_gid"}, bus.grant_id, exp_gid);
      chk({tag, "_data"}, fs_word, word_of(int'(exp_gid)));
      @(negedge clk);
      chk({tag, "_pulse"}, bus.ack, 4'b0);
      bus.req = 4'b0;
      @(negedge clk);
   endtask

   task automatic drive_req();
      for (int i = 0; i < 4; i++) begin
         bus.req[i] = (rq[i].size() != 0);
         if (rq[i].size() != 0) bus.req_data[i * 96 +: 96] = rq[i][0];
      end
   endtask

   initial begin
      logic [3:0] a;
      int len, e, ac0, total, served, pop, cyc;
      int cnt_m[4], pos[4];

      rst = 1'b1;
      bus.req = 4'b0;
      bus.req_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_so", bus.so, 8'h00);
      chk("rst_fs", bus.wr_fs, 1'b0);
      chk("rst_ack", bus.ack, 4'b0);
      chk("rst_data", bus.wr_data, 96'h0);
      chk("rst_gid", bus.grant_id, 2'd3);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_err", bus.err, 1'b0);

      // Single request: latency, data word, byte order, one-cycle ack.
      bus.req_data[95:0] = 96'h0102_0304_0506_0708_090A_0B0C;
      byte_q.delete();
      wr_lat = 15;
      bus.req = 4'b0001;
      @(negedge clk);
      chk("single_arb", bus.so, 8'h01);
      chk("single_busy", bus.busy, 1'b1);
      chk("single_fs1", bus.wr_fs, 1'b0);
      @(negedge clk);
      chk("single_load", bus.so, 8'h02);
      chk("single_fs2", bus.wr_fs, 1'b0);
      @(negedge clk);
      chk("single_fs3", bus.wr_fs, 1'b1);
      chk("single_word", bus.wr_data, 96'h0102_0304_0506_0708_090A_0B0C);
      wait_ack(a, 200);
      chk("single_ack", a, 4'b0001);
      chk("single_err", bus.err, 1'b0);
      @(negedge clk);
      chk("single_pulse", bus.ack, 4'b0);
      bus.req = 4'b0;
      chk("single_nbytes", byte_q.size(), 12);
      if (byte_q.size() >= 12)
         for (int k = 0; k < 12; k++) chk("single_byte", byte_q[k], 8'(k + 1));

      // Arbitration table, starting from the reset grant.
      tbl[0]  = '{4'b1111, 4'b0001, 2'd0};
      tbl[1]  = '{4'b1111, 4'b0010, 2'd1};
      tbl[2]  = '{4'b1111, 4'b0100, 2'd2};
      tbl[3]  = '{4'b1111, 4'b1000, 2'd3};
      tbl[4]  = '{4'b1111, 4'b0001, 2'd0};
      tbl[5]  = '{4'b0010, 4'b0010, 2'd1};
      tbl[6]  = '{4'b1001, 4'b1000, 2'd3};
      tbl[7]  = '{4'b1001, 4'b0001, 2'd0};
      tbl[8]  = '{4'b0110, 4'b0010, 2'd1};
      tbl[9]  = '{4'b0110, 4'b0100, 2'd2};
      tbl[10] = '{4'b1100, 4'b1000, 2'd3};
      tbl[11] = '{4'b0101, 4'b0001, 2'd0};
      tbl[12] = '{4'b1010, 4'b0010, 2'd1};
      tbl[13] = '{4'b1000, 4'b1000, 2'd3};
      tbl[14] = '{4'b0100, 4'b0100, 2'd2};
      reset_dut();
      for (int i = 0; i < 4; i++) bus.req_data[i * 96 +: 96] = word_of(i);
      for (int t = 0; t < 15; t++) run_frame(tbl[t].pat, tbl[t].ack, tbl[t].gid, "tbl");

      // Frame done on the last cycle before timeout wins.
      wr_lat = 64;
      @(negedge clk);
      bus.req = 4'b0001;
      fs_len(len);
      chk("tie_fs_len", len, 64);
      wait_ack(a, 50);
      chk("tie_ack", a, 4'b0001);
      chk("tie_err", bus.err, 1'b0);
      @(negedge clk);
      bus.req = 4'b0;
      wr_lat = 15;

      // Randomized request sets against the round-robin service model.
      reset_dut();
      model_last = 3;
      for (int round = 0; round < 4; round++) begin
         total = 0;
         for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            for (int j = 0; j < $urandom_range(0, 3); j++) rq[i].push_back({$urandom, $urandom, $urandom});
            total += rq[i].size();
         end
         if (total == 0) begin
            rq[round].push_back({$urandom, $urandom, $urandom});
            total = 1;
         end
         for (int i = 0; i < 4; i++) begin
            cnt_m[i] = rq[i].size();
            pos[i] = 0;
         end
         for (int s = 0; s < total; s++) begin
            for (int k = 1; k <= 4; k++) begin
               int idx;
               idx = (model_last + k) % 4;
               if (cnt_m[idx] > 0) begin
                  exp_id_q.push_back(idx);
                  exp_q.push_back(rq[idx][pos[idx]]);
                  cnt_m[idx]--;
                  pos[idx]++;
                  model_last = idx;
                  break;
               end
            end
         end
         served = 0;
         pop = -1;
         cyc = 0;
         wr_lat = $urandom_range(1, 40);
         @(negedge clk);
         drive_req();
         while (served < total && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (pop >= 0) begin
               void'(rq[pop].pop_front());
               drive_req();
               pop = -1;
               wr_lat = $urandom_range(1, 40);
            end
            if (bus.ack != 4'b0) begin
               int eid;
               logic [95:0] ew;
               eid = exp_id_q.pop_front();
               ew = exp_q.pop_front();
               chk("rand_ack", bus.ack, 4'(4'b0001 << eid));
               chk("rand_data", fs_word, ew);
               pop = eid;
               served++;
            end
         end
         chk("rand_served", served, total);
         @(negedge clk);
         if (pop >= 0) void'(rq[pop].pop_front());
         drive_req();
         exp_q.delete();
         exp_id_q.delete();
      end
      chk("rand_err", bus.err, 1'b0);
      bus.req = 4'b0;

      // Timeout: writer silent, sticky error, drain, then the same request again.
      repeat (3) @(negedge clk);
      bus.req_data[95:0] = word_of(0);
      wr_on = 1'b0;
      ac0 = ack_cnt;
      @(negedge clk);
      bus.req = 4'b0001;
      fs_len(len);
      chk("to_fs_len", len, 64);
      e = 0;
      while (bus.so == 8'h0F && e < 100) begin
         @(negedge clk);
         e++;
      end
      chk("to_err_len", e, 16);
      chk("to_err", bus.err, 1'b1);
      chk("to_no_ack", ack_cnt - ac0, 0);
      wr_on = 1'b1;
      wr_lat = 15;
      wait_ack(a, 200);
      chk("to_reack", a, 4'b0001);
      chk("to_err_sticky", bus.err, 1'b1);
      @(negedge clk);
      bus.req = 4'b0;

      // Reset while the frame is being sent.
      @(negedge clk);
      bus.req = 4'b0001;
      e = 0;
      while (!bus.wr_fs && e < 50) begin
         @(negedge clk);
         e++;
      end
      repeat (5) @(negedge clk);
      chk("mid_fs_pre", bus.wr_fs, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_fs", bus.wr_fs, 1'b0);
      chk("mid_so", bus.so, 8'h00);
      chk("mid_gid", bus.grant_id, 2'd3);
      chk("mid_err", bus.err, 1'b0);
      chk("mid_ack", bus.ack, 4'b0);
      rst = 1'b0;
      wait_ack(a, 200);
      chk("mid_serve", a, 4'b0001);
      @(negedge clk);
      bus.req = 4'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
